// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// sequencer states and the bundled per-stage stall/flush controls.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERROR
  } ctrl_state_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } ctrl_t;

  // Whole-pipe freeze used while the data cache refills.
  localparam ctrl_t CTRL_HOLD = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1,
                                  stall_m: 1'b1, flush_d: 1'b0, flush_e: 1'b0,
                                  flush_w: 1'b1};

  // The memory stage holds the younger result, so it wins over writeback.
  function automatic fwd_sel_t fwd_pick(input logic hit_m, input logic hit_w);
    if (hit_m)      return FWD_MEM;
    else if (hit_w) return FWD_WB;
    else            return FWD_REG;
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Execute-stage operand bypass select, one slice per source operand.
module forwarding_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE
);

  logic [1:0][REG_ADDR_WIDTH-1:0] rs;
  logic [1:0][1:0]                sel;
  logic                           wr_m;
  logic                           wr_w;

  assign rs   = {Rs2E, Rs1E};
  // Register x0 is hardwired to zero and is never a bypass source.
  assign wr_m = RegWriteM && (RdM != '0);
  assign wr_w = RegWriteW && (RdW != '0);

  for (genvar i = 0; i < 2; i++) begin : g_opnd
    assign sel[i] = fwd_pick(wr_m && (RdM == rs[i]), wr_w && (RdW == rs[i]));
  end

  assign ForwardAE = sel[0];
  assign ForwardBE = sel[1];

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central 5-stage pipeline sequencer: stall/flush generation, operand
// forwarding, cache-miss hold with timeout, and saturating perf counters.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int CNT_WIDTH       = 32,
  parameter int MAX_MISS_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic                      LoadE,
  input  logic                      PCSrcE,
  input  logic                      cache_miss_i,
  input  logic                      cache_ready_i,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushW,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      err_o,
  output logic [CNT_WIDTH-1:0]      stall_cycles_o,
  output logic [CNT_WIDTH-1:0]      flush_count_o
);

  localparam int WAIT_W = $clog2(MAX_MISS_CYCLES + 1);

  ctrl_state_t       state, state_n;
  logic [WAIT_W-1:0] wait_cnt, wait_n, wait_inc;
  ctrl_t             run_ctrl, ctrl;
  logic              lw_stall;
  logic              flush_evt;

  forwarding_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd (
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE)
  );

  assign lw_stall = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign wait_inc = wait_cnt + WAIT_W'(1);

  // Branch beats load-use: the dependent instruction is squashed anyway.
  always_comb begin
    run_ctrl = '0;
    if (PCSrcE) begin
      run_ctrl.flush_d = 1'b1;
      run_ctrl.flush_e = 1'b1;
    end else if (lw_stall) begin
      run_ctrl.stall_f = 1'b1;
      run_ctrl.stall_d = 1'b1;
      run_ctrl.flush_e = 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    wait_n    = wait_cnt;
    ctrl      = CTRL_HOLD;
    flush_evt = 1'b0;
    case (state)
      RUN: begin
        if (cache_miss_i) begin
          state_n = MEM_WAIT;
          wait_n  = WAIT_W'(1);
        end else begin
          ctrl      = run_ctrl;
          flush_evt = PCSrcE;
        end
      end
      MEM_WAIT: begin
        if (cache_ready_i) begin
          ctrl      = run_ctrl;
          flush_evt = PCSrcE;
          state_n   = RUN;
          wait_n    = '0;
        end else begin
          wait_n = wait_inc;
          if (wait_inc == WAIT_W'(MAX_MISS_CYCLES)) state_n = ERROR;
        end
      end
      default: state_n = ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      wait_cnt       <= '0;
      stall_cycles_o <= '0;
      flush_count_o  <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
      if (ctrl.stall_d && (stall_cycles_o != '1))
        stall_cycles_o <= stall_cycles_o + CNT_WIDTH'(1);
      if (flush_evt && (flush_count_o != '1))
        flush_count_o <= flush_count_o + CNT_WIDTH'(1);
    end
  end

  assign StallF = ctrl.stall_f;
  assign StallD = ctrl.stall_d;
  assign StallE = ctrl.stall_e;
  assign StallM = ctrl.stall_m;
  assign FlushD = ctrl.flush_d;
  assign FlushE = ctrl.flush_e;
  assign FlushW = ctrl.flush_w;
  assign err_o  = (state == ERROR);

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench: a default-size instance plus a small one (4-bit counters,
// 4-cycle miss timeout) driven from the same stimulus.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, LoadE, PCSrcE, cache_miss_i, cache_ready_i;

  logic        m_sf, m_sd, m_se, m_sm, m_fd, m_fe, m_fw, m_err;
  logic [1:0]  m_fa, m_fb;
  logic [31:0] m_stall, m_flush;
  logic        s_sf, s_sd, s_se, s_sm, s_fd, s_fe, s_fw, s_err;
  logic [1:0]  s_fa, s_fb;
  logic [3:0]  s_stall, s_flush;
  logic [6:0]  m_ctrl, s_ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign m_ctrl = {m_sf, m_sd, m_se, m_sm, m_fd, m_fe, m_fw};
  assign s_ctrl = {s_sf, s_sd, s_se, s_sm, s_fd, s_fe, s_fw};

  pipeline_hazard_controller dut_main (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .cache_miss_i(cache_miss_i),
    .cache_ready_i(cache_ready_i), .StallF(m_sf), .StallD(m_sd), .StallE(m_se),
    .StallM(m_sm), .FlushD(m_fd), .FlushE(m_fe), .FlushW(m_fw), .ForwardAE(m_fa),
    .ForwardBE(m_fb), .err_o(m_err), .stall_cycles_o(m_stall), .flush_count_o(m_flush)
  );

  pipeline_hazard_controller #(.CNT_WIDTH(4), .MAX_MISS_CYCLES(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .cache_miss_i(cache_miss_i),
    .cache_ready_i(cache_ready_i), .StallF(s_sf), .StallD(s_sd), .StallE(s_se),
    .StallM(s_sm), .FlushD(s_fd), .FlushE(s_fe), .FlushW(s_fw), .ForwardAE(s_fa),
    .ForwardBE(s_fb), .err_o(s_err), .stall_cycles_o(s_stall), .flush_count_o(s_flush)
  );

  // Control vector order: {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_LOADU  = 7'b1100010;
  localparam logic [6:0] C_BRANCH = 7'b0000110;
  localparam logic [6:0] C_HOLD   = 7'b1111001;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0;
    cache_miss_i = 0; cache_ready_i = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #3;
    chk("reset_ctrl",  m_ctrl,  C_NONE);
    chk("reset_err",   m_err,   1'b0);
    chk("reset_stall", m_stall, 32'd0);
    chk("reset_flush", m_flush, 32'd0);
    tick();
    rst_n = 1'b1;

    // Forwarding priority and x0 exclusion
    Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs2E = 0;
    settle();
    chk("fwdA_mem", m_fa, 2'b10);
    chk("fwdB_none", m_fb, 2'b00);
    RegWriteM = 0;
    settle();
    chk("fwdA_wb", m_fa, 2'b01);
    RdM = 0; RdW = 0; RegWriteM = 1; Rs1E = 0;
    settle();
    chk("fwdA_x0", m_fa, 2'b00);
    chk("fwdB_x0", m_fb, 2'b00);
    Rs1E = 5; RdW = 5; Rs2E = 9; RdM = 9;
    settle();
    chk("fwdB_mem", m_fb, 2'b10);
    chk("fwdA_wb2", m_fa, 2'b01);
    clear_inputs();
    tick();

    // Load-use bubble, and rd=x0 never stalls
    LoadE = 1; RdE = 0; Rs1D = 0;
    settle();
    chk("lw_x0", m_ctrl, C_NONE);
    RdE = 7; Rs1D = 3; Rs2D = 7;
    settle();
    chk("lw_ctrl", m_ctrl, C_LOADU);
    tick();
    chk("lw_cnt", m_stall, 32'd1);
    LoadE = 0;
    settle();
    chk("lw_release", m_ctrl, C_NONE);
    tick();
    chk("lw_cnt_hold", m_stall, 32'd1);

    // Branch beats load-use
    LoadE = 1; RdE = 7; Rs2D = 7; PCSrcE = 1;
    settle();
    chk("br_ctrl", m_ctrl, C_BRANCH);
    tick();
    chk("br_flush_cnt", m_flush, 32'd1);
    chk("br_stall_cnt", m_stall, 32'd1);
    clear_inputs();

    // Cache miss with branch pending: 4 held cycles, one flush after exit
    do_reset();
    cache_miss_i = 1; PCSrcE = 1;
    settle();
    chk("miss_c0", m_ctrl, C_HOLD);
    tick();
    cache_miss_i = 0;
    for (int i = 1; i <= 3; i++) begin
      settle();
      chk($sformatf("miss_c%0d", i), m_ctrl, C_HOLD);
      tick();
    end
    chk("miss_no_flush_yet", m_flush, 32'd0);
    cache_ready_i = 1;
    settle();
    chk("miss_ready", m_ctrl, C_BRANCH);
    tick();
    cache_ready_i = 0; PCSrcE = 0;
    settle();
    chk("miss_after", m_ctrl, C_NONE);
    chk("miss_stall_cnt", m_stall, 32'd4);
    chk("miss_flush_cnt", m_flush, 32'd1);
    chk("miss_err", m_err, 1'b0);
    clear_inputs();

    // Small instance: ready arriving on the last allowed wait cycle wins
    do_reset();
    cache_miss_i = 1;
    tick();
    cache_miss_i = 0;
    tick();
    tick();
    cache_ready_i = 1;
    settle();
    chk("edge_ready_ctrl", s_ctrl, C_NONE);
    tick();
    cache_ready_i = 0;
    settle();
    chk("edge_err", s_err, 1'b0);
    chk("edge_after", s_ctrl, C_NONE);
    chk("edge_stall_cnt", s_stall, 4'd3);

    // Small instance: timeout into ERROR, sticky until reset
    do_reset();
    cache_miss_i = 1;
    tick();
    cache_miss_i = 0;
    tick();
    settle();
    chk("to_early_err", s_err, 1'b0);
    repeat (6) tick();
    settle();
    chk("to_err", s_err, 1'b1);
    chk("to_ctrl", s_ctrl, C_HOLD);
    cache_ready_i = 1;
    tick();
    settle();
    chk("to_sticky", s_err, 1'b1);
    chk("to_sticky_ctrl", s_ctrl, C_HOLD);
    cache_ready_i = 0;
    rst_n = 1'b0;
    #1;
    chk("to_rst_err", s_err, 1'b0);
    chk("to_rst_ctrl", s_ctrl, C_NONE);
    chk("to_rst_stall", s_stall, 4'd0);
    chk("to_rst_flush", s_flush, 4'd0);
    tick();
    rst_n = 1'b1;

    // Saturation of the 4-bit stall counter
    LoadE = 1; RdE = 7; Rs1D = 7;
    repeat (20) tick();
    chk("sat_small", s_stall, 4'd15);
    chk("sat_main", m_stall, 32'd20);
    repeat (3) tick();
    chk("sat_small_hold", s_stall, 4'd15);
    settle();
    chk("sat_ctrl", s_ctrl, C_LOADU);
    clear_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central sequencer for the 5-stage pipeline register files (fetch, decode, execute, memory, writeback).
- Generates per-stage stall (drives `en` low) and flush (drives `clear`) controls, plus execute-stage operand forwarding selects.
- Holds the whole pipe during data-cache misses using a small FSM with a timeout error.
- Keeps saturating stall/flush performance counters.

Parameters:
- REG_ADDR_WIDTH, 5, register index width.
- CNT_WIDTH, 32, width of performance counters.
- MAX_MISS_CYCLES, 64, cache-miss wait cycles before declaring an error (>=2).

Ports:
- clk  input  1  clock; state and counters update on posedge.
- rst_n  input  1  asynchronous active-low reset.
- Rs1D  input  REG_ADDR_WIDTH  decode source register 1.
- Rs2D  input  REG_ADDR_WIDTH  decode source register 2.
- Rs1E  input  REG_ADDR_WIDTH  execute source register 1.
- Rs2E  input  REG_ADDR_WIDTH  execute source register 2.
- RdE  input  REG_ADDR_WIDTH  execute destination.
- RdM  input  REG_ADDR_WIDTH  memory destination.
- RdW  input  REG_ADDR_WIDTH  writeback destination.
- RegWriteM  input  1  memory-stage instruction writes a register.
- RegWriteW  input  1  writeback-stage instruction writes a register.
- LoadE  input  1  execute-stage instruction is a load (ResultSrcE[0]).
- PCSrcE  input  1  branch/jump taken in execute.
- cache_miss_i  input  1  memory-stage access missed this cycle.
- cache_ready_i  input  1  refill complete; memory stage data valid.
- StallF  output  1  hold PC.
- StallD  output  1  hold fetch→decode register (fetch regfile en = !StallD).
- StallE  output  1  hold decode→execute register.
- StallM  output  1  hold execute→memory register.
- FlushD  output  1  clear fetch→decode register.
- FlushE  output  1  clear decode→execute register.
- FlushW  output  1  clear memory→writeback register.
- ForwardAE  output  2  operand A select: 00 regfile, 01 writeback result, 10 memory ALU result.
- ForwardBE  output  2  operand B select, same encoding.
- err_o  output  1  miss timeout; sticky until reset.
- stall_cycles_o  output  CNT_WIDTH  cycles with StallD=1.
- flush_count_o  output  CNT_WIDTH  branch flush events.

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN, wait counter=0, err_o=0, both counters=0.
  - Stall/flush outputs decode from RUN, so they are 0 unless hazard inputs are active.
- Forwarding (combinational, independent of state):
  - ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - Else ForwardAE=01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - Else ForwardAE=00.
  - The memory stage wins when both match. ForwardBE is identical using Rs2E.
- lw_stall = LoadE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- State RUN, all outputs combinational:
  - cache_miss_i=1 takes priority over everything:
    - StallF=StallD=StallE=StallM=1 and FlushW=1; FlushD=FlushE=0.
    - PCSrcE is ignored; it is re-evaluated after the miss because E is frozen.
    - Next state MEM_WAIT; wait counter loads 1.
  - Else PCSrcE=1:
    - FlushD=FlushE=1; StallF=StallD=0.
    - Branch beats load-use because the dependent instruction is squashed anyway.
    - flush_count_o increments.
  - Else lw_stall=1: StallF=StallD=1, FlushE=1 (one-cycle bubble).
  - Else all stall/flush outputs=0.
  - StallE, StallM and FlushW are 1 only on a miss.
- State MEM_WAIT:
  - StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
  - cache_ready_i=1: this cycle's outputs are those of RUN with cache_miss_i treated as 0; next state RUN; wait counter cleared.
  - Else the wait counter increments. When it equals MAX_MISS_CYCLES (and cache_ready_i=0), next state ERROR.
  - cache_ready_i at the exact timeout cycle wins: go to RUN.
- State ERROR:
  - All stalls=1, FlushW=1, err_o=1.
  - Exit only via rst_n.
- Counters:
  - stall_cycles_o increments every posedge where StallD=1, in any state.
  - Both counters saturate at all-ones and do not wrap.
- Reset mid-miss: returns immediately to RUN with all state cleared.

Decomposition:
- pipeline_ctrl_pkg holds:
  - typedef enum logic[1:0] fwd_sel_t {FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}.
  - typedef enum logic[1:0] ctrl_state_t {RUN, MEM_WAIT, ERROR}.
- Sub-module forwarding_unit: combinational, computes ForwardAE/ForwardBE; instantiated once.

Test Plan:
- Forwarding:
  - Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 → ForwardAE=10.
  - Drop RegWriteM → ForwardAE=01.
  - RdM=RdW=0 with both RegWrite=1 → ForwardAE=00.
- Load-use:
  - LoadE=1, RdE=7, Rs2D=7, no branch/miss → StallF=StallD=FlushE=1 for one cycle.
  - Next cycle with LoadE=0 → all stall/flush outputs 0; stall_cycles_o=1.
- Branch + load-use: PCSrcE=1, lw_stall=1 → FlushD=FlushE=1, StallF=StallD=0; flush_count_o increments by 1.
- Cache miss:
  - cache_miss_i pulses, cache_ready_i asserted 3 cycles later → StallF/D/E/M=1 and FlushW=1 for 4 cycles, then RUN.
  - stall_cycles_o=4; PCSrcE held at 1 during the miss causes exactly one flush, after exit.
- Timeout with MAX_MISS_CYCLES=4: miss with no ready → ERROR; err_o=1 and all stalls high indefinitely. Assert rst_n=0 mid-ERROR → err_o=0, state RUN, counters 0 asynchronously.
- Saturation with CNT_WIDTH=4: hold lw_stall 20 cycles → stall_cycles_o=15 and stays there.
